// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - register map, CTRL/STATUS bit positions and FSM state types for the FIFO UART
package uart_pkg;

   localparam logic [2:0] ADDR_CTRL     = 3'd0;
   localparam logic [2:0] ADDR_RXDATA   = 3'd1;
   localparam logic [2:0] ADDR_TXDATA   = 3'd2;
   localparam logic [2:0] ADDR_STATUS   = 3'd3;
   localparam logic [2:0] ADDR_DIV_LO   = 3'd4;
   localparam logic [2:0] ADDR_DIV_HI   = 3'd5;
   localparam logic [2:0] ADDR_RX_LEVEL = 3'd6;
   localparam logic [2:0] ADDR_TX_LEVEL = 3'd7;

   localparam int CTRL_RXIE     = 0;
   localparam int CTRL_TXEIE    = 1;
   localparam int CTRL_LOOPBACK = 2;
   localparam int CTRL_ERRIE    = 3;
   localparam int CTRL_FIFO_CLR = 7;

   localparam int ST_RX_AVAIL  = 0;
   localparam int ST_RX_FULL   = 1;
   localparam int ST_TX_FULL   = 2;
   localparam int ST_TX_EMPTY  = 3;
   localparam int ST_TX_BUSY   = 4;
   localparam int ST_RX_OVR    = 5;
   localparam int ST_FRAME_ERR = 6;
   localparam int ST_TX_OVF    = 7;

   typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} UartTxState;
   typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} UartRxState;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with registered count, single-cycle clear and combinational head
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     clr,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign do_push = push & (~full | do_pop);
   assign rdata   = mem[rptr];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else if (clr) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= wptr + AW'(1);
         if (do_pop)  rptr <= rptr + AW'(1);
         if (do_push && !do_pop)
            count <= count + (AW+1)'(1);
         else if (!do_push && do_pop)
            count <= count - (AW+1)'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (do_push && !clr) mem[wptr] <= wdata;
   end

endmodule

// File: rtl/uart_fifo_component.sv
// rtl/uart_fifo_component.sv - memory-mapped 8N1 UART with RX/TX FIFOs, programmable divisor,
// sticky error flags, loopback and a registered maskable interrupt
module uart_fifo_component #(
   parameter int          FIFO_DEPTH  = 8,
   parameter int          DIV_WIDTH   = 16,
   parameter logic [15:0] DEFAULT_DIV = 16'd103,
   parameter logic [2:0]  IRQ_ID      = 3'b000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       cs,
   input  logic       rd,
   input  logic       wr,
   input  logic [2:0] addr,
   input  logic [7:0] in_data,
   output logic [7:0] out_data,
   input  logic       rx_in,
   output logic       tx_out,
   output logic       irq,
   output logic [2:0] irq_id,
   output logic [7:0] debug
);

   import uart_pkg::*;

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic rd_act, wr_act, rd_prev, wr_prev, rd_pulse, wr_pulse;
   logic wr_ctrl, wr_txdata, wr_status, wr_div_lo, wr_div_hi, fifo_clr;

   logic [3:0]           ctrl;
   logic [DIV_WIDTH-1:0] div_q;
   logic [15:0]          div_ext, div_wr;
   logic                 tx_ovf, frame_err, rx_ovr;
   logic [7:0]           status;

   logic [7:0]    tx_rdata, rx_rdata;
   logic [CW-1:0] tx_count, rx_count;
   logic          tx_full, tx_empty, rx_full, rx_empty;
   logic          tx_pop, rx_push, rx_pop;

   UartTxState           tx_state, tx_next;
   logic [DIV_WIDTH-1:0] tx_cnt, tx_div;
   logic [2:0]           tx_idx;
   logic [7:0]           tx_shreg;
   logic                 tx_tick;

   UartRxState           rx_state, rx_next;
   logic                 rx_src, rx_meta, rx_s, rx_prev, rx_fall, rx_tick, rx_done;
   logic [DIV_WIDTH-1:0] rx_cnt, rx_div, rx_start_cnt;
   logic [DIV_WIDTH:0]   rx_half;
   logic [2:0]           rx_idx;
   logic [7:0]           rx_shreg;

   logic          irq_cond;
   logic [CW+2:0] tx_lvl_pad;

   // Bus strobes act only on their first active cycle.
   assign rd_act   = ~cs & ~rd;
   assign wr_act   = ~cs & ~wr;
   assign rd_pulse = rd_act & ~rd_prev;
   assign wr_pulse = wr_act & ~wr_prev;

   assign wr_ctrl   = wr_pulse & (addr == ADDR_CTRL);
   assign wr_txdata = wr_pulse & (addr == ADDR_TXDATA);
   assign wr_status = wr_pulse & (addr == ADDR_STATUS);
   assign wr_div_lo = wr_pulse & (addr == ADDR_DIV_LO);
   assign wr_div_hi = wr_pulse & (addr == ADDR_DIV_HI);
   assign fifo_clr  = wr_ctrl & in_data[CTRL_FIFO_CLR];
   assign rx_pop    = rd_pulse & (addr == ADDR_RXDATA) & ~rx_empty;

   assign div_ext = 16'(div_q);

   always_comb begin
      div_wr = div_ext;
      if (wr_div_lo) div_wr[7:0]  = in_data;
      if (wr_div_hi) div_wr[15:8] = in_data;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rd_prev   <= 1'b0;
         wr_prev   <= 1'b0;
         ctrl      <= '0;
         div_q     <= DIV_WIDTH'(DEFAULT_DIV);
         tx_ovf    <= 1'b0;
         frame_err <= 1'b0;
         rx_ovr    <= 1'b0;
         irq       <= 1'b0;
      end else begin
         rd_prev <= rd_act;
         wr_prev <= wr_act;
         if (wr_ctrl) ctrl <= in_data[3:0];
         if (wr_div_lo || wr_div_hi) div_q <= DIV_WIDTH'(div_wr);
         // Hardware set wins over a same-cycle write-one-to-clear.
         tx_ovf    <= (wr_txdata & tx_full & ~tx_pop) |
                      (tx_ovf & ~(wr_status & in_data[ST_TX_OVF]));
         frame_err <= (rx_done & ~rx_s) |
                      (frame_err & ~(wr_status & in_data[ST_FRAME_ERR]));
         rx_ovr    <= (rx_done & rx_s & rx_full) |
                      (rx_ovr & ~(wr_status & in_data[ST_RX_OVR]));
         irq       <= irq_cond;
      end
   end

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clock(clock), .reset(reset), .clr(fifo_clr),
      .push(wr_txdata), .pop(tx_pop), .wdata(in_data), .rdata(tx_rdata),
      .count(tx_count), .full(tx_full), .empty(tx_empty)
   );

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clock(clock), .reset(reset), .clr(fifo_clr),
      .push(rx_push), .pop(rx_pop), .wdata(rx_shreg), .rdata(rx_rdata),
      .count(rx_count), .full(rx_full), .empty(rx_empty)
   );

   assign tx_tick = (tx_cnt == '0);

   always_comb begin
      tx_next = tx_state;
      tx_pop  = 1'b0;
      case (tx_state)
         TxIdle: begin
            if (!tx_empty && !fifo_clr) begin
               tx_pop  = 1'b1;
               tx_next = TxStart;
            end
         end
         TxStart: if (tx_tick) tx_next = TxData;
         TxData:  if (tx_tick && tx_idx == 3'd7) tx_next = TxStop;
         TxStop: begin
            if (tx_tick) begin
               if (!tx_empty && !fifo_clr) begin
                  tx_pop  = 1'b1;
                  tx_next = TxStart;
               end else begin
                  tx_next = TxIdle;
               end
            end
         end
         default: tx_next = TxIdle;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) tx_state <= TxIdle;
      else        tx_state <= tx_next;
   end

   // tx_out is registered from the state, so the line trails the FSM by one clock.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         tx_cnt   <= '0;
         tx_div   <= '0;
         tx_idx   <= '0;
         tx_shreg <= '0;
         tx_out   <= 1'b1;
      end else begin
         if (tx_pop) begin
            tx_shreg <= tx_rdata;
            tx_div   <= div_q;
            tx_cnt   <= div_q;
            tx_idx   <= '0;
         end else if (tx_state != TxIdle) begin
            if (tx_tick) begin
               tx_cnt <= tx_div;
               if (tx_state == TxData) begin
                  tx_shreg <= tx_shreg >> 1;
                  tx_idx   <= tx_idx + 3'd1;
               end
            end else begin
               tx_cnt <= tx_cnt - DIV_WIDTH'(1);
            end
         end
         case (tx_state)
            TxStart: tx_out <= 1'b0;
            TxData:  tx_out <= tx_shreg[0];
            default: tx_out <= 1'b1;
         endcase
      end
   end

   assign rx_src  = ctrl[CTRL_LOOPBACK] ? tx_out : rx_in;
   assign rx_fall = rx_prev & ~rx_s;
   assign rx_tick = (rx_cnt == '0);
   assign rx_half = ({1'b0, div_q} + (DIV_WIDTH+1)'(1)) >> 1;
   assign rx_start_cnt = (rx_half == '0) ? '0 : DIV_WIDTH'(rx_half - (DIV_WIDTH+1)'(1));

   always_comb begin
      rx_next = rx_state;
      rx_done = 1'b0;
      case (rx_state)
         RxIdle:  if (rx_fall) rx_next = RxStart;
         RxStart: if (rx_tick) rx_next = rx_s ? RxIdle : RxData;
         RxData:  if (rx_tick && rx_idx == 3'd7) rx_next = RxStop;
         RxStop: begin
            if (rx_tick) begin
               rx_next = RxIdle;
               rx_done = 1'b1;
            end
         end
         default: rx_next = RxIdle;
      endcase
   end

   assign rx_push = rx_done & rx_s & ~rx_full;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) rx_state <= RxIdle;
      else        rx_state <= rx_next;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rx_meta  <= 1'b1;
         rx_s     <= 1'b1;
         rx_prev  <= 1'b1;
         rx_cnt   <= '0;
         rx_div   <= '0;
         rx_idx   <= '0;
         rx_shreg <= '0;
      end else begin
         rx_meta <= rx_src;
         rx_s    <= rx_meta;
         rx_prev <= rx_s;
         if (rx_state == RxIdle) begin
            if (rx_fall) begin
               rx_div <= div_q;
               rx_cnt <= rx_start_cnt;
               rx_idx <= '0;
            end
         end else if (rx_tick) begin
            rx_cnt <= rx_div;
            if (rx_state == RxData) begin
               rx_shreg <= {rx_s, rx_shreg[7:1]};
               rx_idx   <= rx_idx + 3'd1;
            end
         end else begin
            rx_cnt <= rx_cnt - DIV_WIDTH'(1);
         end
      end
   end

   always_comb begin
      status               = '0;
      status[ST_RX_AVAIL]  = ~rx_empty;
      status[ST_RX_FULL]   = rx_full;
      status[ST_TX_FULL]   = tx_full;
      status[ST_TX_EMPTY]  = tx_empty;
      status[ST_TX_BUSY]   = (tx_state != TxIdle);
      status[ST_RX_OVR]    = rx_ovr;
      status[ST_FRAME_ERR] = frame_err;
      status[ST_TX_OVF]    = tx_ovf;
   end

   always_comb begin
      out_data = 8'h00;
      case (addr)
         ADDR_CTRL:     out_data = {4'b0000, ctrl};
         ADDR_RXDATA:   out_data = rx_empty ? 8'h00 : rx_rdata;
         ADDR_TXDATA:   out_data = 8'h00;
         ADDR_STATUS:   out_data = status;
         ADDR_DIV_LO:   out_data = div_ext[7:0];
         ADDR_DIV_HI:   out_data = div_ext[15:8];
         ADDR_RX_LEVEL: out_data = 8'(rx_count);
         ADDR_TX_LEVEL: out_data = 8'(tx_count);
         default:       out_data = 8'h00;
      endcase
   end

   assign irq_cond = (ctrl[CTRL_RXIE]  & status[ST_RX_AVAIL]) |
                     (ctrl[CTRL_TXEIE] & status[ST_TX_EMPTY] & ~status[ST_TX_BUSY]) |
                     (ctrl[CTRL_ERRIE] & (rx_ovr | frame_err | tx_ovf));

   assign irq_id     = IRQ_ID;
   assign tx_lvl_pad = {tx_count, 3'b000};
   assign debug      = {tx_state, 1'b0, rx_state, tx_lvl_pad[CW+2 -: 3]};

endmodule

// File: doc/uart_fifo_component.md
Name: uart_fifo_component

Overview:
Memory-mapped UART, successor to the single-buffer UART component, on the same system bus (cs/rd/wr active low, 3-bit addr, 8-bit data).
Adds parametrised RX/TX FIFOs, a runtime-programmable baud divisor, sticky error flags, loopback, and a level-sensitive maskable interrupt.
Contains its own TX serializer, RX deserializer and baud timing.
Frame format is fixed at 8N1, LSB first.

Parameters:
FIFO_DEPTH, 8, entries per FIFO; must be a power of 2 and ≥2.
DIV_WIDTH, 16, width of the baud divisor.
DEFAULT_DIV, 16'd103, divisor reset value; bit period = DIV+1 clocks.
IRQ_ID, 3'b000, constant driven on irq_id.

Ports:
clock  in  1  system clock.
reset  in  1  asynchronous, active-low reset.
cs  in  1  chip select, active low.
rd  in  1  read strobe, active low.
wr  in  1  write strobe, active low.
addr  in  3  register select.
in_data  in  8  write data.
out_data  out  8  read data, combinational from addr.
rx_in  in  1  serial input, asynchronous.
tx_out  out  1  serial output, idle high.
irq  out  1  interrupt, active high, level.
irq_id  out  3  equals IRQ_ID.
debug  out  8  {tx_state[1:0], rx_state[2:0], tx_level_msbs[2:0]}, 0 at reset.

Behaviour:
- Reset (async, reset=0):
  - tx_out=1, irq=0, debug=0.
  - FIFOs empty, CTRL=0, STATUS sticky bits=0, DIV=DEFAULT_DIV.
  - Both engines go to IDLE; any in-flight frame is abandoned.
- Access strobes:
  - rd_act = ~cs & ~rd; wr_act = ~cs & ~wr.
  - Side effects (push, pop, register write, W1C) occur only on the first cycle of an active strobe; the strobe's previous value is registered for edge detection.
  - A strobe held for N cycles acts exactly once.
- Register map:
  - 0 CTRL rw:
    - b0 RXIE; b1 TXEIE; b2 LOOPBACK; b3 ERRIE.
    - b7 FIFO_CLR: write-only, self-clearing, empties both FIFOs in 1 cycle; reads 0.
  - 1 RXDATA ro: head of RX FIFO; read pops it. Reading an empty FIFO returns 0x00 with no pop.
  - 2 TXDATA wo: write pushes. Writing a full FIFO drops the byte and sets TX_OVF.
  - 3 STATUS: reads {TX_OVF, FRAME_ERR, RX_OVR, TX_BUSY, TX_EMPTY, TX_FULL, RX_FULL, RX_AVAIL} (b7..b0). Writing 1 to b7/b6/b5 clears that bit (W1C); other bits are read-only.
  - 4 DIV_LO, 5 DIV_HI: rw. The divisor is latched by each engine at frame start, so a mid-frame change affects only the next frame.
  - 6 RX_LEVEL ro: RX entry count (0..FIFO_DEPTH). 7 TX_LEVEL ro: TX entry count.
- FIFO:
  - Synchronous, registered count.
  - Push and pop in the same cycle are legal: count unchanged, data preserved.
  - Pointers wrap modulo FIFO_DEPTH; full when count==FIFO_DEPTH.
- TX FSM: IDLE → START → DATA → STOP → IDLE.
  - IDLE: if TX FIFO is non-empty, pop, latch the byte and DIV, go to START; tx_out goes low on the next clock.
  - Start-bit latency: 2 clocks from the write strobe's first cycle.
  - Each bit lasts DIV+1 clocks. A frame is 10*(DIV+1) clocks.
  - Back-to-back frames have no idle gap.
  - TX_BUSY = (state≠IDLE).
  - FIFO_CLR mid-frame: the current frame completes.
- RX path:
  - Source is tx_out when LOOPBACK=1, else rx_in. It passes through a 2-FF synchronizer (sync latency not counted below).
- RX FSM: IDLE → START → DATA → STOP → IDLE.
  - IDLE: a falling edge latches DIV and enters START.
  - START: wait (DIV+1)>>1 clocks, then sample. If high, it is a false start: return to IDLE with no flag.
  - DATA: 8 samples spaced DIV+1 apart, LSB first.
  - STOP: sample DIV+1 later.
    - Stop=0: set FRAME_ERR, discard the byte.
    - Stop=1 and RX FIFO full: set RX_OVR, drop the new byte, keep the FIFO contents.
    - Otherwise push the byte.
  - Returns to IDLE right after the stop sample (mid-stop-bit), so back-to-back frames are received.
- Simultaneous events:
  - If a hardware set and a W1C of the same sticky bit land in one cycle, the set wins.
  - An RX push coinciding with a CPU pop is legal.
- irq = (RXIE & RX_AVAIL) | (TXEIE & TX_EMPTY & ~TX_BUSY) | (ERRIE & (RX_OVR|FRAME_ERR|TX_OVF)), registered (1-clock latency). irq stays asserted until the condition clears.

Decomposition:
- Package uart_pkg holds:
  - register address localparams;
  - CTRL/STATUS bit-index localparams;
  - enums UartTxState {TxIdle, TxStart, TxData, TxStop} and UartRxState {RxIdle, RxStart, RxData, RxStop}.
- One sub-module: sync_fifo (params WIDTH, DEPTH; ports clock, reset, clr, push, pop, wdata, rdata, count, full, empty), instantiated twice.

Test Plan:
1. DIV=3, write 0xA5 to TXDATA → tx_out low 2 clocks after the strobe, then bits 1,0,1,0,0,1,0,1 (LSB first), stop high, 4 clocks each, 40 clocks total; TX_BUSY then clears.
2. LOOPBACK=1, DIV=3, write 0x3C,0x81,0xFF → RX_LEVEL=3; RXDATA reads return 0x3C,0x81,0xFF; a 4th read returns 0x00 with RX_LEVEL=0.
3. FIFO_DEPTH=8, drive 9 frames on rx_in without reading → RX_FULL=1, RX_OVR=1, first 8 bytes intact; write 0x20 to STATUS → RX_OVR=0.
4. Drive frame 0x55 with stop bit=0 → FRAME_ERR=1, RX_LEVEL=0; with ERRIE=1, irq=1 until W1C 0x40.
5. RXIE=1, receive 0x12 → irq rises 1 clock after the push; hold rd low 5 cycles on addr 1 → exactly one pop, irq falls.
6. Assert reset mid-TX frame with tx_out=0 → tx_out=1 immediately; after release, DIV=DEFAULT_DIV and STATUS=0x08 (TX_EMPTY only).
